clm_sbox_arbiter: RTL and testbench

Arbitration and sequencing unit sharing one masked CLM S-box instance between the round datapath (SubBytes, one state word per request) and the key-expansion unit (SubWord). Sits between the top-level controller's two requesters and the S-box `drdy_i`/`drdy_o` handshake. Keeps one S-box operation in flight, arbitrates fairly, and recovers via a watchdog if the S-box never answers.

---
 rtl/clm_sbox_arbiter.sv | 137 +++++++++++++
 tb/tb_clm_sbox_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clm_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : clm_sbox_arbiter
// Description : Shares one masked CLM S-box between the round datapath and
//               the key-expansion unit. Round-robin arbitration, one S-box
//               operation in flight, and a watchdog for a silent S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module clm_sbox_arbiter #(
    parameter int D       = 4,
    parameter int MAX_LAT = 16,
    localparam int c_WORD_W = 4 * (8 + D),
    localparam int c_MASK_W = 7 * D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req,
    input  logic [c_WORD_W-1:0] rd_in,
    input  logic [c_MASK_W-1:0] rd_r,
    output logic                rd_gnt,
    output logic                rd_done,
    output logic [c_WORD_W-1:0] rd_out,
    input  logic                ks_req,
    input  logic [c_WORD_W-1:0] ks_in,
    input  logic [c_MASK_W-1:0] ks_r,
    output logic                ks_gnt,
    output logic                ks_done,
    output logic [c_WORD_W-1:0] ks_out,
    output logic                sb_drdy_i,
    output logic [c_WORD_W-1:0] sb_in,
    output logic [c_MASK_W-1:0] sb_r,
    input  logic                sb_drdy_o,
    input  logic [c_WORD_W-1:0] sb_out,
    output logic                busy,
    output logic                err
);

    // Wide enough to hold MAX_LAT itself, so it cannot wrap before timeout.
    localparam int c_CNT_W = $clog2(MAX_LAT) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                r_ptr_ks;    // 1: key expansion holds priority
    logic                r_owner_ks;  // 1: current operation belongs to key expansion
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_timeout;
    logic                w_any_req;
    logic                w_pick_ks;
    logic [c_WORD_W-1:0] r_op_in;
    logic [c_MASK_W-1:0] r_op_r;
    logic [c_WORD_W-1:0] r_rd_out;
    logic [c_WORD_W-1:0] r_ks_out;
    logic                r_err;

    assign w_any_req = rd_req | ks_req;
    // A lone requester wins outright; on contention the pointer decides.
    assign w_pick_ks = ks_req & (~rd_req | r_ptr_ks);
    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    assign w_timeout = (w_cnt_inc == c_CNT_W'(MAX_LAT));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a response wins over a simultaneous timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req) w_state_next = c_ISSUE;
            c_ISSUE: w_state_next = c_WAIT;
            c_WAIT:  if (sb_drdy_o || w_timeout) w_state_next = c_RESP;
            c_RESP:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Arbitration, operand capture, latency counter, result and error capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr_ks   <= 1'b1;
            r_owner_ks <= 1'b0;
            r_cnt      <= '0;
            r_op_in    <= '0;
            r_op_r     <= '0;
            r_rd_out   <= '0;
            r_ks_out   <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner_ks <= w_pick_ks;
                        r_ptr_ks   <= ~w_pick_ks;
                        r_op_in    <= w_pick_ks ? ks_in : rd_in;
                        r_op_r     <= w_pick_ks ? ks_r  : rd_r;
                    end
                end
                c_ISSUE: r_cnt <= '0;
                c_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (sb_drdy_o) begin
                        if (r_owner_ks) r_ks_out <= sb_out;
                        else            r_rd_out <= sb_out;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign sb_drdy_i = (r_state == c_ISSUE);
    assign rd_gnt    = (r_state == c_ISSUE) & ~r_owner_ks;
    assign ks_gnt    = (r_state == c_ISSUE) &  r_owner_ks;
    assign rd_done   = (r_state == c_RESP)  & ~r_owner_ks;
    assign ks_done   = (r_state == c_RESP)  &  r_owner_ks;
    assign sb_in     = r_op_in;
    assign sb_r      = r_op_r;
    assign rd_out    = r_rd_out;
    assign ks_out    = r_ks_out;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clm_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clm_sbox_arbiter
// Description : Directed self-checking bench for clm_sbox_arbiter with a
//               behavioural S-box of programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clm_sbox_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0, ks_req = 1'b0;
    logic [47:0] rd_in = '0, ks_in = '0;
    logic [27:0] rd_r = '0, ks_r = '0;
    logic        rd_gnt, rd_done, ks_gnt, ks_done;
    logic [47:0] rd_out, ks_out;
    logic        sb_drdy_i;
    logic [47:0] sb_in;
    logic [27:0] sb_r;
    logic        sb_drdy_o = 1'b0;
    logic [47:0] sb_out = '0;
    logic        busy, err;

    int checks = 0;
    int failures = 0;

    // S-box model state: m_lat = 0 means never answer.
    int          m_lat = 7;
    int          m_rem = 0;
    logic [47:0] m_in = '0;
    logic [27:0] m_r = '0;
    logic        m_spur = 1'b0;

    logic [47:0] exp_rd = '0, exp_ks = '0;

    clm_sbox_arbiter #(.D(4), .MAX_LAT(16)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_in(rd_in), .rd_r(rd_r),
        .rd_gnt(rd_gnt), .rd_done(rd_done), .rd_out(rd_out),
        .ks_req(ks_req), .ks_in(ks_in), .ks_r(ks_r),
        .ks_gnt(ks_gnt), .ks_done(ks_done), .ks_out(ks_out),
        .sb_drdy_i(sb_drdy_i), .sb_in(sb_in), .sb_r(sb_r),
        .sb_drdy_o(sb_drdy_o), .sb_out(sb_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] sbox_f(input logic [47:0] a, input logic [27:0] r);
        return {a[23:0], a[47:24]} ^ {20'h0, r} ^ 48'h5A5A_5A5A_5A5A;
    endfunction

    // Behavioural S-box: a strobe seen in cycle 1 yields a response in cycle 1+L.
    always @(negedge clk) begin
        sb_drdy_o = 1'b0;
        if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                sb_drdy_o = 1'b1;
                sb_out    = sbox_f(m_in, m_r);
            end
        end
        if (sb_drdy_i && m_lat > 0) begin
            m_rem = m_lat;
            m_in  = sb_in;
            m_r   = sb_r;
        end
        if (m_spur) begin
            sb_drdy_o = 1'b1;
            sb_out    = 48'hDEAD_BEEF_0BAD;
        end
    end

    task automatic do_reset();
        rd_req = 1'b0; ks_req = 1'b0; m_lat = 7; m_spur = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_rd = '0; exp_ks = '0;
    endtask

    // Issue one request in cycle 0 and report the cycles of grant, done, first err.
    task automatic run_op(input bit use_ks, input logic [47:0] din, input logic [27:0] rin,
                          input int lat, output int gnt_c, output int done_c, output int err_c);
        m_lat = lat; gnt_c = -1; done_c = -1; err_c = -1;
        if (use_ks) begin ks_in = din; ks_r = rin; ks_req = 1'b1; end
        else        begin rd_in = din; rd_r = rin; rd_req = 1'b1; end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if ((use_ks ? ks_gnt : rd_gnt) && gnt_c < 0) begin
                gnt_c = c; ks_req = 1'b0; rd_req = 1'b0;
            end
            if (err && err_c < 0) err_c = c;
            if (use_ks ? ks_done : rd_done) begin done_c = c; break; end
        end
        rd_req = 1'b0; ks_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rd_gnt, ks_gnt, rd_done, ks_done, sb_drdy_i, busy, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 0000000", {rd_gnt, ks_gnt, rd_done, ks_done, sb_drdy_i, busy, err});
        end
        checks++;
        if ({rd_out, ks_out, sb_in, sb_r} !== 172'b0) begin
            failures++;
            $display("FAIL reset_data: rd_out=%h ks_out=%h sb_in=%h sb_r=%h want all 0", rd_out, ks_out, sb_in, sb_r);
        end
    endtask

    task automatic test_single();
        int gnt_c = -1, sbi_c = -1, done_c = -1, ndone = 0;
        do_reset();
        m_lat = 7; rd_in = 48'h123456789ABC; rd_r = 28'h1234567; rd_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rd_gnt && gnt_c < 0) begin
                gnt_c = c;
                checks++;
                if (sb_in !== 48'h123456789ABC || sb_r !== 28'h1234567) begin
                    failures++;
                    $display("FAIL single_operands: sb_in=%h sb_r=%h want 123456789abc 1234567", sb_in, sb_r);
                end
                rd_req = 1'b0;
            end
            if (sb_drdy_i && sbi_c < 0) sbi_c = c;
            if (rd_done) begin done_c = c; ndone++; end
            checks++;
            if (busy !== (c <= 9)) begin
                failures++;
                $display("FAIL single_busy cycle %0d: got %b want %b", c, busy, (c <= 9));
            end
        end
        checks++;
        if (gnt_c != 1 || sbi_c != 1 || done_c != 9 || ndone != 1) begin
            failures++;
            $display("FAIL single_timing: gnt=%0d drdy_i=%0d done=%0d ndone=%0d want 1 1 9 1", gnt_c, sbi_c, done_c, ndone);
        end
        exp_rd = sbox_f(48'h123456789ABC, 28'h1234567);
        checks++;
        if (rd_out !== exp_rd || ks_out !== 48'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_result: rd_out=%h ks_out=%h err=%b want %h 0 0", rd_out, ks_out, err, exp_rd);
        end
    endtask

    task automatic test_both();
        int kg = -1, kd = -1, rg = -1, rdn = -1;
        do_reset();
        m_lat = 7;
        rd_in = 48'hAAAA_0000_1111; rd_r = 28'h0A0A0A0;
        ks_in = 48'h5555_FFFF_2222; ks_r = 28'h0505050;
        rd_req = 1'b1; ks_req = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (ks_gnt && kg < 0) begin kg = c; ks_req = 1'b0; end
            if (rd_gnt && rg < 0) begin rg = c; rd_req = 1'b0; end
            if (ks_done && kd < 0) kd = c;
            if (rd_done && rdn < 0) rdn = c;
        end
        checks++;
        if (kg != 1 || kd != 9 || rg != 11 || rdn != 19) begin
            failures++;
            $display("FAIL both_timing: ks_gnt=%0d ks_done=%0d rd_gnt=%0d rd_done=%0d want 1 9 11 19", kg, kd, rg, rdn);
        end
        exp_ks = sbox_f(48'h5555_FFFF_2222, 28'h0505050);
        exp_rd = sbox_f(48'hAAAA_0000_1111, 28'h0A0A0A0);
        checks++;
        if (ks_out !== exp_ks || rd_out !== exp_rd) begin
            failures++;
            $display("FAIL both_results: ks_out=%h rd_out=%h want %h %h", ks_out, rd_out, exp_ks, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        int n_gnt = 0, n_done = 0;
        logic [5:0] order = '0;
        logic [47:0] rd_cur_in = '0, ks_cur_in = '0;
        logic [27:0] rd_cur_r = '0, ks_cur_r = '0;
        do_reset();
        m_lat = 3;
        rd_in = 48'h0102_0304_0506; rd_r = 28'h1000001;
        ks_in = 48'hF0E0_D0C0_B0A0; ks_r = 28'h2000002;
        rd_req = 1'b1; ks_req = 1'b1;
        for (int c = 1; c <= 100 && n_done < 6; c++) begin
            @(negedge clk);
            if (ks_gnt) begin
                if (n_gnt < 6) order[n_gnt] = 1'b1;
                n_gnt++;
                ks_cur_in = ks_in; ks_cur_r = ks_r;
                ks_in = ks_in + 48'h0101_0101_0101; ks_r = ks_r + 28'h11;
            end
            if (rd_gnt) begin
                n_gnt++;
                rd_cur_in = rd_in; rd_cur_r = rd_r;
                rd_in = rd_in + 48'h0202_0202_0202; rd_r = rd_r + 28'h23;
            end
            if (n_gnt >= 6) begin rd_req = 1'b0; ks_req = 1'b0; end
            if (ks_done) begin
                n_done++;
                exp_ks = sbox_f(ks_cur_in, ks_cur_r);
                checks++;
                if (ks_out !== exp_ks || rd_out !== exp_rd) begin
                    failures++;
                    $display("FAIL b2b_ks_done %0d: ks_out=%h rd_out=%h want %h %h", n_done, ks_out, rd_out, exp_ks, exp_rd);
                end
            end
            if (rd_done) begin
                n_done++;
                exp_rd = sbox_f(rd_cur_in, rd_cur_r);
                checks++;
                if (rd_out !== exp_rd || ks_out !== exp_ks) begin
                    failures++;
                    $display("FAIL b2b_rd_done %0d: rd_out=%h ks_out=%h want %h %h", n_done, rd_out, ks_out, exp_rd, exp_ks);
                end
            end
        end
        rd_req = 1'b0; ks_req = 1'b0;
        @(negedge clk);
        checks++;
        if (n_gnt != 6 || n_done != 6 || order !== 6'b010101) begin
            failures++;
            $display("FAIL b2b_order: grants=%0d dones=%0d order=%b want 6 6 010101", n_gnt, n_done, order);
        end
    endtask

    task automatic test_spurious();
        m_spur = 1'b1;
        rd_req = 1'b1;
        #2 rd_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) m_spur = 1'b0;
            checks++;
            if ({rd_gnt, ks_gnt, rd_done, ks_done, busy} !== 5'b0) begin
                failures++;
                $display("FAIL spurious_idle cycle %0d: gnt/done/busy=%b want 00000", c, {rd_gnt, ks_gnt, rd_done, ks_done, busy});
            end
        end
        checks++;
        if (rd_out !== exp_rd || ks_out !== exp_ks) begin
            failures++;
            $display("FAIL spurious_outs: rd_out=%h ks_out=%h want %h %h", rd_out, ks_out, exp_rd, exp_ks);
        end
    endtask

    task automatic test_timeout();
        int g, d, e;
        do_reset();
        run_op(1'b1, 48'h1111_2222_3333, 28'h0123456, 3, g, d, e);
        exp_ks = sbox_f(48'h1111_2222_3333, 28'h0123456);
        run_op(1'b1, 48'h4444_5555_6666, 28'h0FEDCBA, 0, g, d, e);
        checks++;
        if (d != 18 || e != 18) begin
            failures++;
            $display("FAIL timeout_cycle: done=%0d err=%0d want 18 18", d, e);
        end
        checks++;
        if (ks_out !== exp_ks || rd_out !== 48'h0) begin
            failures++;
            $display("FAIL timeout_out_kept: ks_out=%h rd_out=%h want %h 0", ks_out, rd_out, exp_ks);
        end
        run_op(1'b0, 48'h7777_8888_9999, 28'h0246802, 5, g, d, e);
        exp_rd = sbox_f(48'h7777_8888_9999, 28'h0246802);
        checks++;
        if (d != 7 || err !== 1'b1 || rd_out !== exp_rd) begin
            failures++;
            $display("FAIL err_sticky: done=%0d err=%b rd_out=%h want 7 1 %h", d, err, rd_out, exp_rd);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared: err=%b want 0", err);
        end
        run_op(1'b1, 48'hABCD_EF01_2345, 28'h0135790, 16, g, d, e);
        exp_ks = sbox_f(48'hABCD_EF01_2345, 28'h0135790);
        checks++;
        if (d != 18 || e != -1 || ks_out !== exp_ks) begin
            failures++;
            $display("FAIL max_lat_ok: done=%0d err_cycle=%0d ks_out=%h want 18 -1 %h", d, e, ks_out, exp_ks);
        end
    endtask

    task automatic test_reset_mid_wait();
        int ndone = 0, first = -1;
        m_lat = 7;
        ks_in = 48'h0F0F_0F0F_0F0F; ks_r = 28'h0777777; ks_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (ks_gnt) ks_req = 1'b0;
            if (rd_done || ks_done) ndone++;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({rd_gnt, ks_gnt, rd_done, ks_done, sb_drdy_i, busy, err, rd_out, ks_out, sb_in, sb_r} !== 179'b0) begin
            failures++;
            $display("FAIL midwait_zero: busy=%b err=%b rd_out=%h ks_out=%h sb_in=%h sb_r=%h want all 0",
                     busy, err, rd_out, ks_out, sb_in, sb_r);
        end
        for (int c = 6; c <= 14; c++) begin
            @(negedge clk);
            if (rd_done || ks_done || busy) ndone++;
        end
        checks++;
        if (ndone != 0 || rd_out !== 48'h0 || ks_out !== 48'h0) begin
            failures++;
            $display("FAIL midwait_discard: activity=%0d rd_out=%h ks_out=%h want 0 0 0", ndone, rd_out, ks_out);
        end
        rd_in = 48'h1; ks_in = 48'h2; rd_req = 1'b1; ks_req = 1'b1;
        for (int c = 1; c <= 5 && first < 0; c++) begin
            @(negedge clk);
            if (ks_gnt) first = 1;
            else if (rd_gnt) first = 0;
        end
        rd_req = 1'b0; ks_req = 1'b0;
        checks++;
        if (first != 1) begin
            failures++;
            $display("FAIL midwait_ptr: first grant=%0d want 1 (ks)", first);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_back_to_back();
        test_spurious();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
